// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the 8-bit CPU control path. It holds the sequencer
// state enum, the instruction opcodes, the ALU operation codes, the BUS1 and
// BUS2 select codes, and the CCR flag bit positions.
// There are no ports. Import it with "import cpu_pkg::*;".
// ----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH0 = 4'd0,
    S_FETCH1 = 4'd1,
    S_DECODE = 4'd2,
    S_OP0    = 4'd3,
    S_OP1    = 4'd4,
    S_DATA0  = 4'd5,
    S_DATA1  = 4'd6,
    S_EXEC   = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  // Opcodes
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD     = 8'h42;
  localparam logic [7:0] OP_SUB     = 8'h43;
  localparam logic [7:0] OP_AND     = 8'h44;
  localparam logic [7:0] OP_OR      = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_DECA    = 8'h47;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BEQ     = 8'h21;
  localparam logic [7:0] OP_BNE     = 8'h22;
  localparam logic [7:0] OP_BMI     = 8'h23;
  localparam logic [7:0] OP_BCS     = 8'h24;
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_HLT     = 8'hFF;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_INC = 4'd4;
  localparam logic [3:0] ALU_DEC = 4'd5;

  // BUS1 sources
  localparam logic [1:0] BUS1_PC = 2'd0;
  localparam logic [1:0] BUS1_A  = 2'd1;
  localparam logic [1:0] BUS1_B  = 2'd2;

  // BUS2 sources
  localparam logic [2:0] BUS2_ALU  = 3'd0;
  localparam logic [2:0] BUS2_BUS1 = 3'd1;
  localparam logic [2:0] BUS2_MEM  = 3'd2;
  localparam logic [2:0] BUS2_IMM  = 3'd3;
  localparam logic [2:0] BUS2_ADDR = 3'd4;

  // CCR flag positions {N,Z,V,C}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // An ALU opcode maps directly to its ALU operation code.
  function automatic logic [3:0] aluSelFor(input logic [7:0] op);
    case (op)
      OP_ADD:  aluSelFor = ALU_ADD;
      OP_SUB:  aluSelFor = ALU_SUB;
      OP_AND:  aluSelFor = ALU_AND;
      OP_OR:   aluSelFor = ALU_OR;
      OP_INCA: aluSelFor = ALU_INC;
      OP_DECA: aluSelFor = ALU_DEC;
      default: aluSelFor = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// ----------------------------------------------------------------------------
// branch_eval
// Combinational branch condition evaluator.
// Ports:
//   IR         : current instruction (one of the branch opcodes)
//   CCR_Result : flags {N,Z,V,C}
//   taken      : 1 when the branch in IR should be taken
// Any opcode that is not a branch reports "not taken".
// ----------------------------------------------------------------------------
module branch_eval
  import cpu_pkg::*;
(
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       taken
);

  // Pick the flag that each conditional branch tests.
  always_comb begin
    taken = 1'b0;
    case (IR)
      OP_BRA:  taken = 1'b1;
      OP_BEQ:  taken = CCR_Result[FLAG_Z];
      OP_BNE:  taken = ~CCR_Result[FLAG_Z];
      OP_BMI:  taken = CCR_Result[FLAG_N];
      OP_BCS:  taken = CCR_Result[FLAG_C];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU data path.
// Ports:
//   clk, reset         : rising-edge clock and synchronous active-low reset
//   IR, CCR_Result     : instruction register and flags from the data path
//   IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load : data-path strobes
//   Bus1_Sel, Bus2_Sel : bus source selects
//   addr_sel           : 0 = PC drives the address, 1 = MAR drives it
//   ALU_Sel            : ALU operation (non-zero only in S_EXEC)
//   reg_we, reg_sel    : register-file write enable and target (0=A, 1=B)
//   mem_we             : memory write enable
//   halted             : high while in S_HALT
// All outputs are Moore: they are decoded from the state and IR, and from
// CCR_Result in S_OP1.
// ----------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [2:0] Bus2_Sel,
  output logic       addr_sel,
  output logic [3:0] ALU_Sel,
  output logic       reg_we,
  output logic       reg_sel,
  output logic       mem_we,
  output logic       halted
);

  state_t state_q, state_d;
  logic   taken;

  branch_eval u_branch_eval (
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .taken      (taken)
  );

  // Reset wins from every state, including S_HALT and mid-instruction.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    CCR_Load = 1'b0;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    addr_sel = 1'b0;
    ALU_Sel  = ALU_ADD;
    reg_we   = 1'b0;
    reg_sel  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_FETCH0: state_d = S_FETCH1;

      // The opcode is on the memory bus here because the read latency is one
      // cycle after the PC was presented in S_FETCH0.
      S_FETCH1: begin
        Bus2_Sel = BUS2_MEM;
        IR_Load  = 1'b1;
        PC_Inc   = 1'b1;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        case (IR)
          OP_LDA_IMM, OP_LDA_DIR, OP_LDB_IMM, OP_LDB_DIR,
          OP_STA_DIR, OP_STB_DIR,
          OP_BRA, OP_BEQ, OP_BNE, OP_BMI, OP_BCS:  state_d = S_OP0;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_INCA, OP_DECA:                        state_d = S_EXEC;
          OP_HLT:                                  state_d = S_HALT;
          default:                                 state_d = S_FETCH0;
        endcase
      end

      S_OP0: state_d = S_OP1;

      // The operand byte (immediate, direct address or branch target) arrives
      // from memory in this state.
      S_OP1: begin
        state_d = S_FETCH0;
        case (IR)
          OP_LDA_IMM, OP_LDB_IMM: begin
            Bus2_Sel = BUS2_MEM;
            reg_we   = 1'b1;
            reg_sel  = (IR == OP_LDB_IMM);
            PC_Inc   = 1'b1;
          end
          OP_LDA_DIR, OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: begin
            Bus2_Sel = BUS2_MEM;
            MAR_Load = 1'b1;
            PC_Inc   = 1'b1;
            state_d  = S_DATA0;
          end
          OP_BRA, OP_BEQ, OP_BNE, OP_BMI, OP_BCS: begin
            if (taken) begin
              Bus2_Sel = BUS2_MEM;
              PC_Load  = 1'b1;
            end else begin
              PC_Inc   = 1'b1;
            end
          end
          default: state_d = S_FETCH0;
        endcase
      end

      S_DATA0: begin
        state_d = S_FETCH0;
        case (IR)
          OP_LDA_DIR, OP_LDB_DIR: begin
            addr_sel = 1'b1;
            state_d  = S_DATA1;
          end
          OP_STA_DIR, OP_STB_DIR: begin
            addr_sel = 1'b1;
            Bus1_Sel = (IR == OP_STB_DIR) ? BUS1_B : BUS1_A;
            mem_we   = 1'b1;
          end
          default: state_d = S_FETCH0;
        endcase
      end

      S_DATA1: begin
        addr_sel = 1'b1;
        Bus2_Sel = BUS2_MEM;
        reg_we   = 1'b1;
        reg_sel  = (IR == OP_LDB_DIR);
        state_d  = S_FETCH0;
      end

      S_EXEC: begin
        Bus1_Sel = BUS1_A;
        Bus2_Sel = BUS2_ALU;
        ALU_Sel  = aluSelFor(IR);
        reg_we   = 1'b1;
        reg_sel  = 1'b0;
        CCR_Load = 1'b1;
        state_d  = S_FETCH0;
      end

      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end

      default: state_d = S_FETCH0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
// Directed testbench for control_unit. Every output is packed into one vector
// and compared each cycle against a hand-written expected vector.
// ----------------------------------------------------------------------------
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load;
  logic [1:0] Bus1_Sel;
  logic [2:0] Bus2_Sel;
  logic       addr_sel;
  logic [3:0] ALU_Sel;
  logic       reg_we, reg_sel, mem_we, halted;

  int checkCount;
  int errorCount;

  logic [18:0] outVec;
  logic [18:0] zeroVec;
  logic [18:0] fetch1Vec;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .IR_Load    (IR_Load),
    .MAR_Load   (MAR_Load),
    .PC_Load    (PC_Load),
    .PC_Inc     (PC_Inc),
    .CCR_Load   (CCR_Load),
    .Bus1_Sel   (Bus1_Sel),
    .Bus2_Sel   (Bus2_Sel),
    .addr_sel   (addr_sel),
    .ALU_Sel    (ALU_Sel),
    .reg_we     (reg_we),
    .reg_sel    (reg_sel),
    .mem_we     (mem_we),
    .halted     (halted)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every DUT output, in the same field order as vec().
  assign outVec = {IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, Bus1_Sel,
                   Bus2_Sel, addr_sel, ALU_Sel, reg_we, reg_sel, mem_we, halted};

  // Builds an expected output vector from named fields.
  function automatic logic [18:0] vec(input logic irl, input logic marl,
                                      input logic pcl, input logic pci,
                                      input logic ccrl, input logic [1:0] b1,
                                      input logic [2:0] b2, input logic as,
                                      input logic [3:0] alu, input logic rwe,
                                      input logic rsel, input logic mwe,
                                      input logic h);
    vec = {irl, marl, pcl, pci, ccrl, b1, b2, as, alu, rwe, rsel, mwe, h};
  endfunction

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [18:0] observed,
                             input logic [18:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %05h expected %05h", tag, observed, expected);
    end
  endtask

  // Sets the DUT inputs. Called shortly after a rising edge.
  task automatic applyStimulus(input logic rst, input logic [7:0] ir,
                               input logic [3:0] ccr);
    reset      = rst;
    IR         = ir;
    CCR_Result = ccr;
  endtask

  // Advances one clock and checks the outputs of the state just entered.
  task automatic stepCheck(input string tag, input logic [18:0] expected);
    @(posedge clk);
    #1;
    checkOutput(tag, outVec, expected);
  endtask

  // Runs a branch from S_FETCH0 back to the next S_FETCH0.
  task automatic runBranch(input string tag, input logic [7:0] op,
                           input logic [3:0] ccr, input logic expectTaken);
    applyStimulus(1'b1, op, ccr);
    stepCheck({tag, " fetch1"}, fetch1Vec);
    stepCheck({tag, " decode"}, zeroVec);
    stepCheck({tag, " op0"}, zeroVec);
    if (expectTaken)
      stepCheck({tag, " op1"}, vec(0,0,1,0,0,2'd0,3'd2,0,4'd0,0,0,0,0));
    else
      stepCheck({tag, " op1"}, vec(0,0,0,1,0,2'd0,3'd0,0,4'd0,0,0,0,0));
    stepCheck({tag, " fetch0"}, zeroVec);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    zeroVec    = '0;
    fetch1Vec  = vec(1,0,0,1,0,2'd0,3'd2,0,4'd0,0,0,0,0);

    // Reset held for three edges, then a NOP.
    applyStimulus(1'b0, 8'h00, 4'h0);
    for (int i = 0; i < 3; i++) stepCheck("reset hold", zeroVec);
    applyStimulus(1'b1, 8'h00, 4'h0);
    stepCheck("nop fetch1", fetch1Vec);
    stepCheck("nop decode", zeroVec);
    stepCheck("nop fetch0", zeroVec);

    // LDA_DIR: seven cycles.
    applyStimulus(1'b1, 8'h87, 4'h0);
    stepCheck("lda_dir fetch1", fetch1Vec);
    stepCheck("lda_dir decode", zeroVec);
    stepCheck("lda_dir op0", zeroVec);
    stepCheck("lda_dir op1", vec(0,1,0,1,0,2'd0,3'd2,0,4'd0,0,0,0,0));
    stepCheck("lda_dir data0", vec(0,0,0,0,0,2'd0,3'd0,1,4'd0,0,0,0,0));
    stepCheck("lda_dir data1", vec(0,0,0,0,0,2'd0,3'd2,1,4'd0,1,0,0,0));
    stepCheck("lda_dir fetch0", zeroVec);

    // LDB_DIR: the write targets B.
    applyStimulus(1'b1, 8'h89, 4'h0);
    stepCheck("ldb_dir fetch1", fetch1Vec);
    stepCheck("ldb_dir decode", zeroVec);
    stepCheck("ldb_dir op0", zeroVec);
    stepCheck("ldb_dir op1", vec(0,1,0,1,0,2'd0,3'd2,0,4'd0,0,0,0,0));
    stepCheck("ldb_dir data0", vec(0,0,0,0,0,2'd0,3'd0,1,4'd0,0,0,0,0));
    stepCheck("ldb_dir data1", vec(0,0,0,0,0,2'd0,3'd2,1,4'd0,1,1,0,0));
    stepCheck("ldb_dir fetch0", zeroVec);

    // STB_DIR: six cycles, one memory write from B.
    applyStimulus(1'b1, 8'h97, 4'h0);
    stepCheck("stb_dir fetch1", fetch1Vec);
    stepCheck("stb_dir decode", zeroVec);
    stepCheck("stb_dir op0", zeroVec);
    stepCheck("stb_dir op1", vec(0,1,0,1,0,2'd0,3'd2,0,4'd0,0,0,0,0));
    stepCheck("stb_dir data0", vec(0,0,0,0,0,2'd2,3'd0,1,4'd0,0,0,1,0));
    stepCheck("stb_dir fetch0", zeroVec);

    // STA_DIR: the write comes from A.
    applyStimulus(1'b1, 8'h96, 4'h0);
    stepCheck("sta_dir fetch1", fetch1Vec);
    stepCheck("sta_dir decode", zeroVec);
    stepCheck("sta_dir op0", zeroVec);
    stepCheck("sta_dir op1", vec(0,1,0,1,0,2'd0,3'd2,0,4'd0,0,0,0,0));
    stepCheck("sta_dir data0", vec(0,0,0,0,0,2'd1,3'd0,1,4'd0,0,0,1,0));
    stepCheck("sta_dir fetch0", zeroVec);

    // Branches, taken and not taken.
    runBranch("beq z=1", 8'h21, 4'b0100, 1'b1);
    runBranch("beq z=0", 8'h21, 4'b0000, 1'b0);
    runBranch("bne z=0", 8'h22, 4'b0000, 1'b1);
    runBranch("bne z=1", 8'h22, 4'b0100, 1'b0);
    runBranch("bmi n=1", 8'h23, 4'b1000, 1'b1);
    runBranch("bmi n=0", 8'h23, 4'b0111, 1'b0);
    runBranch("bcs c=1", 8'h24, 4'b0001, 1'b1);
    runBranch("bcs c=0", 8'h24, 4'b1110, 1'b0);
    runBranch("bra", 8'h20, 4'b0000, 1'b1);

    // SUB and INCA: four cycles, ALU result written to A.
    applyStimulus(1'b1, 8'h43, 4'h0);
    stepCheck("sub fetch1", fetch1Vec);
    stepCheck("sub decode", zeroVec);
    stepCheck("sub exec", vec(0,0,0,0,1,2'd1,3'd0,0,4'd1,1,0,0,0));
    stepCheck("sub fetch0", zeroVec);
    applyStimulus(1'b1, 8'h46, 4'h0);
    stepCheck("inca fetch1", fetch1Vec);
    stepCheck("inca decode", zeroVec);
    stepCheck("inca exec", vec(0,0,0,0,1,2'd1,3'd0,0,4'd4,1,0,0,0));
    stepCheck("inca fetch0", zeroVec);
    applyStimulus(1'b1, 8'h47, 4'h0);
    stepCheck("deca fetch1", fetch1Vec);
    stepCheck("deca decode", zeroVec);
    stepCheck("deca exec", vec(0,0,0,0,1,2'd1,3'd0,0,4'd5,1,0,0,0));
    stepCheck("deca fetch0", zeroVec);

    // LDB_IMM: five cycles, write to B.
    applyStimulus(1'b1, 8'h88, 4'h0);
    stepCheck("ldb_imm fetch1", fetch1Vec);
    stepCheck("ldb_imm decode", zeroVec);
    stepCheck("ldb_imm op0", zeroVec);
    stepCheck("ldb_imm op1", vec(0,0,0,1,0,2'd0,3'd2,0,4'd0,1,1,0,0));
    stepCheck("ldb_imm fetch0", zeroVec);

    // An undefined opcode behaves like a NOP.
    applyStimulus(1'b1, 8'h55, 4'h0);
    stepCheck("undef fetch1", fetch1Vec);
    stepCheck("undef decode", zeroVec);
    stepCheck("undef fetch0", zeroVec);

    // Reset during S_DATA0 of LDA_DIR must suppress the S_DATA1 write.
    applyStimulus(1'b1, 8'h87, 4'h0);
    stepCheck("midreset fetch1", fetch1Vec);
    stepCheck("midreset decode", zeroVec);
    stepCheck("midreset op0", zeroVec);
    stepCheck("midreset op1", vec(0,1,0,1,0,2'd0,3'd2,0,4'd0,0,0,0,0));
    stepCheck("midreset data0", vec(0,0,0,0,0,2'd0,3'd0,1,4'd0,0,0,0,0));
    applyStimulus(1'b0, 8'h87, 4'h0);
    stepCheck("midreset fetch0", zeroVec);
    applyStimulus(1'b1, 8'h00, 4'h0);
    stepCheck("midreset then fetch1", fetch1Vec);
    stepCheck("midreset then decode", zeroVec);
    stepCheck("midreset then fetch0", zeroVec);

    // HLT holds S_HALT until reset.
    applyStimulus(1'b1, 8'hFF, 4'h0);
    stepCheck("hlt fetch1", fetch1Vec);
    stepCheck("hlt decode", zeroVec);
    for (int i = 0; i < 20; i++)
      stepCheck("hlt halted", vec(0,0,0,0,0,2'd0,3'd0,0,4'd0,0,0,0,1));
    applyStimulus(1'b0, 8'h00, 4'h0);
    stepCheck("halt reset", zeroVec);
    applyStimulus(1'b1, 8'h00, 4'h0);
    stepCheck("after halt fetch1", fetch1Vec);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction sequencer that drives the 8-bit CPU data path. It holds the fetch/decode/execute state machine and decodes the instruction register. Every cycle it emits the data-path load, increment and bus-select strobes, plus register-file and memory write enables. It sits directly upstream of the data path and consumes that block's `IR` and `CCR_Result` outputs.

## Interface
Parameters: none. Encodings are fixed in `cpu_pkg`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `IR` input 8: current instruction register from the data path.
- `CCR_Result` input 4: flags {N,Z,V,C}, with bit3=N, bit2=Z, bit1=V, bit0=C.
- `IR_Load`, `MAR_Load`, `PC_Load`, `PC_Inc`, `CCR_Load` output 1 each: data-path strobes.
- `Bus1_Sel` output 2: 0=PC, 1=A, 2=B.
- `Bus2_Sel` output 3: 0=ALU, 1=BUS1, 2=memory, 3=immediate, 4=address.
- `addr_sel` output 1: 0=PC drives address, 1=MAR drives address.
- `ALU_Sel` output 4: ALU operation.
- `reg_we` output 1: register-file write of BUS2.
- `reg_sel` output 1: write target, 0=A, 1=B.
- `mem_we` output 1: memory write of `to_memory` at `address`.
- `halted` output 1: high while in S_HALT.

## Operation
- Memory read latency is 1 cycle. An address presented in cycle n gives `from_memory` valid in cycle n+1.
- All outputs are Moore, decoded from state plus `IR` (and plus `CCR_Result` in branch states). Any strobe not listed for a state is 0.
- States and outputs:
  - S_FETCH0: `addr_sel`=0. Next state S_FETCH1.
  - S_FETCH1: `Bus2_Sel`=2, `IR_Load`=1, `PC_Inc`=1. Next state S_DECODE.
  - S_DECODE: no strobes. Next state by opcode:
    - LD/ST/branch go to S_OP0.
    - ALU ops go to S_EXEC.
    - HLT goes to S_HALT.
    - NOP and any undefined opcode go to S_FETCH0.
  - S_OP0: `addr_sel`=0. Next state S_OP1.
  - S_OP1, by opcode:
    - LD_IMM: `Bus2_Sel`=2, `reg_we`=1, `reg_sel` from opcode, `PC_Inc`=1. Next S_FETCH0.
    - LD_DIR / ST_DIR: `Bus2_Sel`=2, `MAR_Load`=1, `PC_Inc`=1. Next S_DATA0.
    - Branch taken: `Bus2_Sel`=2, `PC_Load`=1. Next S_FETCH0.
    - Branch not taken: `PC_Inc`=1. Next S_FETCH0.
  - S_DATA0, by opcode:
    - LD_DIR: `addr_sel`=1. Next S_DATA1.
    - ST_DIR: `addr_sel`=1, `Bus1_Sel`=1 (A) or 2 (B), `mem_we`=1. Next S_FETCH0.
  - S_DATA1 (LD_DIR): `addr_sel`=1, `Bus2_Sel`=2, `reg_we`=1, `reg_sel` from opcode. Next S_FETCH0.
  - S_EXEC: `Bus1_Sel`=1, `Bus2_Sel`=0, `ALU_Sel` from opcode, `reg_we`=1, `reg_sel`=0, `CCR_Load`=1. Next S_FETCH0.
  - S_HALT: `halted`=1. Remains in S_HALT until reset.
- Opcodes (hex) and actions:
  - 86: LDA_IMM.
  - 87: LDA_DIR.
  - 88: LDB_IMM.
  - 89: LDB_DIR.
  - 96: STA_DIR.
  - 97: STB_DIR.
  - 42 ADD, 43 SUB, 44 AND, 45 OR: A ← A op B.
  - 46 INCA, 47 DECA: A ← A ± 1.
  - 20: BRA, always taken.
  - 21: BEQ, taken if Z=1.
  - 22: BNE, taken if Z=0.
  - 23: BMI, taken if N=1.
  - 24: BCS, taken if C=1.
  - 00: NOP.
  - FF: HLT.
- ALU_Sel encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 INC, 5 DEC. ALU_Sel is 0 outside S_EXEC.
- The branch condition is sampled from `CCR_Result` in S_OP1.

## Timing
- Reset: when `reset`=0 at a clock edge, the state becomes S_FETCH0. This applies from any state, including mid-instruction and S_HALT.
  - In the cycle after that edge, all outputs are 0, which is the S_FETCH0 decode.
  - While `reset` is held low, the state stays S_FETCH0 and no strobe other than `addr_sel`=0 is emitted.
- Cycles per instruction:
  - NOP / undefined: 3.
  - ALU: 4.
  - LD_IMM: 5.
  - Branch: 5, taken or not.
  - ST_DIR: 6.
  - LD_DIR: 7.
- `PC_Load` and `PC_Inc` are never both 1 in the same cycle.
- `mem_we` and `reg_we` are never both 1 in the same cycle.
- PC wrap-around (FF→00) is handled by the data path; the sequencer behaves identically across the wrap.
- A flag update written in S_EXEC is visible to a branch whose S_OP1 follows. At least 4 cycles separate them, so there is no hazard.

## Structure
- `cpu_pkg` holds:
  - `state_t` enum (9 states).
  - Opcode localparams.
  - ALU_Sel constants.
  - Bus1/Bus2 select constants.
  - Flag bit indices.
- Single module: one state register plus combinational next-state/output logic.
- Optional sub-module `branch_eval`: combinational, takes `IR` and `CCR_Result`, outputs `taken`.

## Test plan
- Reset and fetch: hold `reset`=0 for 3 cycles, release, supply `IR`=00.
  - Outputs are all 0 except `addr_sel`=0 during reset.
  - Then FETCH0 → FETCH1 (`IR_Load`=1, `PC_Inc`=1) → DECODE → FETCH0.
- LDA_DIR: `IR`=87.
  - 7-cycle sequence.
  - `MAR_Load`=1 in S_OP1.
  - `addr_sel`=1 in S_DATA0 and S_DATA1.
  - `reg_we`=1, `reg_sel`=0, `Bus2_Sel`=2 only in S_DATA1.
- STB_DIR: `IR`=97.
  - `mem_we`=1 with `Bus1_Sel`=2 and `addr_sel`=1 for exactly one cycle (cycle 6).
  - `reg_we` stays 0 throughout.
- BEQ: `IR`=21.
  - With `CCR_Result`=4'b0100: `PC_Load`=1, `PC_Inc`=0 in S_OP1.
  - With `CCR_Result`=4'b0000: `PC_Inc`=1, `PC_Load`=0.
- SUB: `IR`=43. In S_EXEC: `ALU_Sel`=1, `Bus2_Sel`=0, `reg_we`=1, `CCR_Load`=1, `reg_sel`=0.
- HLT and mid-op reset:
  - `IR`=FF leads to `halted`=1, held for 20 cycles.
  - Assert `reset`=0 during S_DATA0 of an LDA_DIR: the next state is S_FETCH0, and no `reg_we` pulse occurs.
